// File: rtl/sr_flag_pkg.sv
// Shared types for the SR flag scheduler: controller state encoding and
// the {S,R} command codes.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACKW  = 2'd2
  } state_e;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// above ptr, wrapping around, and reports it one-hot and encoded.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [NREQ-1:0] rot;
  int              sum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    sum   = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (!valid && rot[j]) begin
        valid = 1'b1;
        sum   = int'(ptr) + j;
      end
    end
    idx   = PW'((sum >= NREQ) ? (sum - NREQ) : sum);
    grant = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sr_flag_scheduler.sv
// Round-robin scheduler applying set/clear/hold commands to a bank of SR flags.
// Optional macro SR_FLAG_TOGGLE_EN makes command 11 toggle the flag instead of erroring.
module sr_flag_scheduler
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  localparam int AW = (NFLAG > 1) ? $clog2(NFLAG) : 1,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ-1:0]   CMD_S,
  input  logic [NREQ-1:0]   CMD_R,
  input  logic [NREQ*AW-1:0] ADDR,
  output logic [NREQ-1:0]   ACK,
  output logic              ERR,
  output logic              BUSY,
  output logic [NFLAG-1:0]  Q,
  output logic [1:0]        dbg_state,
  output logic [PW-1:0]     dbg_ptr
);

  // Handshake: a requester holds REQ with a stable command until it sees a
  // one-cycle ACK; it then drops REQ or presents a new command.

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [NFLAG-1:0] q_q, q_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  gnt_onehot;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_valid;
  int               addr_i;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (REQ),
    .ptr   (ptr_q),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    q_d     = q_q;
    ack_d   = '0;
    err_d   = 1'b0;
    addr_i  = int'(addr_q);
    unique case (state_q)
      IDLE: begin
        if (gnt_valid && (gnt_onehot != '0)) begin
          win_d   = gnt_idx;
          cmd_d   = {CMD_S[gnt_idx], CMD_R[gnt_idx]};
          addr_d  = ADDR[gnt_idx*AW +: AW];
          ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        ack_d   = NREQ'(1) << win_q;
        state_d = ACKW;
        if (addr_i >= NFLAG) begin
          err_d = 1'b1;
        end else begin
          unique case (cmd_q)
            CMD_HOLD: q_d = q_q;
            CMD_CLR:  q_d[addr_q] = 1'b0;
            CMD_SET:  q_d[addr_q] = 1'b1;
            CMD_BOTH: begin
`ifdef SR_FLAG_TOGGLE_EN
              q_d[addr_q] = ~q_q[addr_q];
`else
              err_d = 1'b1;
`endif
            end
            default:  q_d = q_q;
          endcase
        end
      end
      ACKW: begin
        // No arbitration here, so the just-acknowledged REQ is not re-granted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cmd_q   <= CMD_HOLD;
      addr_q  <= '0;
      q_q     <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ACK       = ack_q;
  assign ERR       = err_q;
  assign BUSY      = (state_q != IDLE);
  assign Q         = q_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Self-checking bench for sr_flag_scheduler (NREQ=4, NFLAG=6) with a
// transaction-level reference model of arbitration and flag updates.
module tb_sr_flag_scheduler;
  import sr_flag_pkg::*;

  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int AW    = 3;
  localparam int PW    = 2;

  logic              CLK;
  logic              RST_N;
  logic [NREQ-1:0]   REQ;
  logic [NREQ-1:0]   CMD_S;
  logic [NREQ-1:0]   CMD_R;
  logic [NREQ*AW-1:0] ADDR;
  logic [NREQ-1:0]   ACK;
  logic              ERR;
  logic              BUSY;
  logic [NFLAG-1:0]  Q;
  logic [1:0]        dbg_state;
  logic [PW-1:0]     dbg_ptr;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [NFLAG-1:0] q_m;
  int               ptr_m;
  bit               pend[NREQ];
  int               s_m[NREQ];
  int               r_m[NREQ];
  int               a_m[NREQ];

  sr_flag_scheduler #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ       (REQ),
    .CMD_S     (CMD_S),
    .CMD_R     (CMD_R),
    .ADDR      (ADDR),
    .ACK       (ACK),
    .ERR       (ERR),
    .BUSY      (BUSY),
    .Q         (Q),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      REQ[i]            = pend[i];
      CMD_S[i]          = s_m[i][0];
      CMD_R[i]          = r_m[i][0];
      ADDR[i*AW +: AW]  = AW'(a_m[i]);
    end
  endtask

  task automatic model_clear();
    q_m   = '0;
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; s_m[i] = 0; r_m[i] = 0; a_m[i] = 0;
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_clear();
    drive();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic post(input int i, input int s, input int r, input int a);
    pend[i] = 1'b1; s_m[i] = s; r_m[i] = r; a_m[i] = a;
  endtask

  // One full grant/apply/ack transaction, entered with the DUT idle.
  task automatic do_op(input bit perturb, input bit reissue, output int w);
    int ls, lr, la;
    logic [NREQ-1:0] exp_ack;
    logic            exp_err;
    w = -1;
    for (int j = 0; j < NREQ; j++) begin
      int c;
      c = (ptr_m + j) % NREQ;
      if (w < 0 && pend[c]) w = c;
    end
    if (w < 0) return;
    ls = s_m[w]; lr = r_m[w]; la = a_m[w];
    ptr_m   = (w + 1) % NREQ;
    exp_ack = NREQ'(1) << w;
    exp_err = 1'b0;
    if (la >= NFLAG) exp_err = 1'b1;
    else if (ls == 1 && lr == 0) q_m[la] = 1'b1;
    else if (ls == 0 && lr == 1) q_m[la] = 1'b0;
    else if (ls == 1 && lr == 1) begin
`ifdef SR_FLAG_TOGGLE_EN
      q_m[la] = ~q_m[la];
`else
      exp_err = 1'b1;
`endif
    end

    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_after_grant: got %b want 1", BUSY); end
    checks++;
    if (ACK !== '0) begin errors++; $display("FAIL ack_early: got %b want 0000", ACK); end
    if (perturb) begin
      a_m[w] = $urandom_range(0, 7);
      s_m[w] = $urandom_range(0, 1);
      r_m[w] = $urandom_range(0, 1);
      drive();
    end

    @(posedge CLK); #1;
    checks++;
    if (ACK !== exp_ack) begin errors++; $display("FAIL ack: got %b want %b", ACK, exp_ack); end
    checks++;
    if (ERR !== exp_err) begin errors++; $display("FAIL err: got %b want %b (req %0d cmd %0d%0d addr %0d)", ERR, exp_err, w, ls, lr, la); end
    checks++;
    if (Q !== q_m) begin errors++; $display("FAIL q: got %b want %b", Q, q_m); end
    if (reissue && $urandom_range(0, 3) == 0)
      post(w, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
    else
      pend[w] = 1'b0;
    drive();

    @(posedge CLK); #1;
    checks++;
    if (ACK !== '0 || ERR !== 1'b0) begin errors++; $display("FAIL ack_clear: ack %b err %b want 0000/0", ACK, ERR); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_return: busy %b want 0", BUSY); end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    model_clear();
    drive();
    #2;
    checks++;
    if (Q !== '0 || ACK !== '0 || ERR !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: q %b ack %b err %b busy %b want zeros", Q, ACK, ERR, BUSY);
    end
    checks++;
    if (dbg_state !== IDLE || dbg_ptr !== '0) begin
      errors++; $display("FAIL reset_state: state %0d ptr %0d want 0/0", dbg_state, dbg_ptr);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_set_clear();
    int w;
    post(2, 1, 0, 5); drive();
    do_op(1'b0, 1'b0, w);
    checks++;
    if (Q[5] !== 1'b1) begin errors++; $display("FAIL set_q5: got %b want 1", Q[5]); end
    post(2, 0, 1, 5); drive();
    do_op(1'b0, 1'b0, w);
    checks++;
    if (Q[5] !== 1'b0) begin errors++; $display("FAIL clear_q5: got %b want 0", Q[5]); end
  endtask

  task automatic test_all_four();
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) post(i, 1, 0, i);
    drive();
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 1'b0, w);
      checks++;
      if (w != i) begin errors++; $display("FAIL rr_order: got %0d want %0d", w, i); end
    end
    checks++;
    if (Q[3:0] !== 4'hF) begin errors++; $display("FAIL all_four_q: got %h want f", Q[3:0]); end
  endtask

  task automatic test_reset_mid_apply();
    post(1, 1, 0, 4); drive();
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", BUSY); end
    RST_N = 1'b0;
    model_clear();
    drive();
    #1;
    checks++;
    if (Q !== '0 || ACK !== '0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL mid_reset: q %b ack %b busy %b err %b want zeros", Q, ACK, BUSY, ERR);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (ACK !== '0 || dbg_state !== IDLE || dbg_ptr !== '0 || Q !== '0) begin
        errors++; $display("FAIL after_reset: ack %b state %0d ptr %0d q %b want 0/0/0/0", ACK, dbg_state, dbg_ptr, Q);
      end
    end
  endtask

  task automatic test_both();
    int w;
    post(0, 1, 0, 1); drive();
    do_op(1'b0, 1'b0, w);
    post(0, 1, 1, 1); drive();
    do_op(1'b0, 1'b0, w);
  endtask

  task automatic test_out_of_range();
    int w;
    post(3, 1, 0, 7); drive();
    @(posedge CLK); #1;
    // Retarget to an in-range flag after the grant; must not take effect.
    a_m[3] = 2;
    drive();
    a_m[3] = 7;
    // Manual ack check; model: ERR with Q untouched.
    ptr_m = 0;
    @(posedge CLK); #1;
    checks++;
    if (ACK !== 4'b1000 || ERR !== 1'b1) begin errors++; $display("FAIL oor_ack_err: ack %b err %b want 1000/1", ACK, ERR); end
    checks++;
    if (Q !== q_m) begin errors++; $display("FAIL oor_q: got %b want %b", Q, q_m); end
    pend[3] = 1'b0; drive();
    @(posedge CLK); #1;
    post(2, 1, 0, 6); drive();
    do_op(1'b0, 1'b0, w);
  endtask

  task automatic test_drop();
    post(0, 1, 0, 0); drive();
    q_m[0] = 1'b1;
    ptr_m  = 1;
    @(posedge CLK); #1;
    post(1, 1, 0, 4); drive();
    @(posedge CLK); #1;
    checks++;
    if (ACK !== 4'b0001) begin errors++; $display("FAIL drop_first_ack: got %b want 0001", ACK); end
    pend[0] = 1'b0; pend[1] = 1'b0; drive();
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (ACK !== '0 || (c > 0 && BUSY !== 1'b0)) begin
        errors++; $display("FAIL drop_no_ack: ack %b busy %b want 0000/0", ACK, BUSY);
      end
    end
    checks++;
    if (Q !== q_m) begin errors++; $display("FAIL drop_q: got %b want %b", Q, q_m); end
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          post(i, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
      begin
        bit any;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) any |= pend[i];
        if (!any) post($urandom_range(0, NREQ - 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
      end
      drive();
      do_op(1'b1, 1'b1, w);
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
  endtask

  initial begin
    model_clear();
    drive();
    test_reset();
    test_set_clear();
    test_all_four();
    test_reset_mid_apply();
    test_both();
    test_out_of_range();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
